mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
Shares one unsigned 32x32 multiplier among NUM_REQ requesters through a round-robin arbiter and sequencer. The block grants one request at a time and holds the operands stable on the multiplier inputs for the multiplier's register latency. It then captures the 64-bit product and returns it on a shared valid/ready response channel tagged with the requester ID. It sits between the CPU's mult/multu issue sources and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, requester ID width; must equal max(1, clog2(NUM_REQ)).
MUL_LAT, 1, register stages in the multiplier (operands sampled at an edge, product valid combinationally MUL_LAT edges later); legal range 1..4.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_a  in  NUM_REQ*32  operand a, requester i at bits [32i+31:32i]
req_b  in  NUM_REQ*32  operand b, same packing
req_signed  in  NUM_REQ  per-requester signed-operation flag (used only with MULT_SIGNED_EN)
mul_a  out  32  multiplier operand a
mul_b  out  32  multiplier operand b
mul_z  in  64  multiplier product
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester index of the response
rsp_z  out  64  product

Behaviour:
- Reset (async, high): state=IDLE, rr_ptr=NUM_REQ-1, so requester 0 has top priority first. req_ready=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_z=0, wait counter=0, sign flag=0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Pick the first i with req_valid[i]=1, searching from rr_ptr+1 and wrapping modulo NUM_REQ.
  - req_ready[i]=1 combinationally in that same cycle; the handshake completes there.
  - At the edge: latch operands into mul_a/mul_b, latch ID, set rr_ptr=i, cnt=0, go to WAIT.
  - With no valid request, stay in IDLE with req_ready=0.
- WAIT:
  - mul_a/mul_b held constant; req_ready=0.
  - cnt increments each cycle.
  - When cnt==MUL_LAT, capture mul_z into rsp_z at the edge and go to DONE. WAIT lasts exactly MUL_LAT+1 cycles.
- DONE:
  - rsp_valid=1; rsp_id/rsp_z held stable until rsp_ready=1.
  - On handshake, go to IDLE with rsp_valid=0 at the next edge.
  - No new grant in the DONE cycle.
- Latency: rsp_valid rises exactly MUL_LAT+2 cycles after the request-handshake cycle. Throughput is at most one op per MUL_LAT+3 cycles with rsp_ready held high.
- req_valid dropped or operands changed after the handshake: no effect on the op in flight.
- All requesters valid continuously: grants cycle 0,1,2,...,NUM_REQ-1,0 in strict rotation.
- Single requester valid continuously: it is granted every op.
- mul_a/mul_b keep their last values in IDLE/DONE; nothing is zeroed between ops.
- Reset asserted mid-WAIT or mid-DONE: the op is discarded, with no response and everything to reset values. The multiplier is reset by the same signal.
- Arithmetic: unsigned 32x32 gives a 64-bit product with no truncation.

Optional Feature:
Macro MULT_SIGNED_EN.
- Defined:
  - A grant with req_signed[i]=1 drives mul_a=|a| and mul_b=|b| (two's-complement magnitude; 0x80000000 maps to 0x80000000 unsigned).
  - It records neg=a[31]^b[31].
  - At capture, rsp_z = neg ? (~mul_z+1) mod 2^64 : mul_z.
  - Unsigned requests behave as without the macro.
- Not defined: req_signed is ignored, no sign logic is instantiated, and all ops are unsigned.

Test Plan:
- Reset mid-WAIT, then release -> rsp_valid stays 0, state IDLE; the next request from req 0 completes normally.
- Req 2 only, a=0x00000003, b=0x00000005, MUL_LAT=1, handshake at cycle t -> rsp_valid at t+3, rsp_id=2, rsp_z=0x000000000000000F.
- a=b=0xFFFFFFFF, unsigned -> rsp_z=0xFFFFFFFE00000001.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; req_ready one-hot each time; one op per 4 cycles.
- rsp_ready held 0 for 5 cycles in DONE -> rsp_z/rsp_id stable, req_ready stays 0 for all, no new grant; the grant occurs in the cycle after rsp_ready=1.
- MULT_SIGNED_EN, req_signed=1, a=0xFFFFFFFD (-3), b=5 -> rsp_z=0xFFFFFFFFFFFFFFF1. a=0x80000000, b=0x80000000 signed -> rsp_z=0x4000000000000000.

Source files
------------

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the mult/multu issue sources and the
// shared-multiplier arbiter. The master side is the requester group, the
// slave side is the arbiter.
interface mul_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  // Request channel, one lane per requester; operand i lives at [32i+31:32i].
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_signed;

  // Shared response channel, tagged with the originating requester.
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_z;

  modport master (
    output req_valid, req_a, req_b, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z
  );

  modport slave (
    input  req_valid, req_a, req_b, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one 32x32 multiplier between
// NUM_REQ requesters. One op in flight: grant in IDLE, hold operands for
// MUL_LAT+1 cycles in WAIT, present the product in DONE until accepted.
// Optional build macro MULT_SIGNED_EN adds signed-magnitude handling on top
// of the unsigned multiplier; without it req_signed is ignored.
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  mul_share_arbiter_if.slave  bus,
  output logic [31:0]         mul_a_o,
  output logic [31:0]         mul_b_o,
  input  logic [63:0]         mul_z_i
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       mul_a_q, mul_a_d;
  logic [31:0]       mul_b_q, mul_b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [63:0]       rsp_z_q, rsp_z_d;
`ifdef MULT_SIGNED_EN
  logic              neg_q, neg_d;
`endif

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;
  logic              sel_signed;
  logic [NUM_REQ-1:0] req_ready;
  int                rr_idx;

  // Round-robin search: first valid requester after rr_ptr, wrapping.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      if (!grant_found && bus.req_valid[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(rr_idx);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a      = bus.req_a[int'(grant_idx)*32 +: 32];
    sel_b      = bus.req_b[int'(grant_idx)*32 +: 32];
    sel_signed = bus.req_signed[grant_idx];
  end

  // One-hot accept in IDLE only; masked during reset so a requester never
  // sees a handshake that the held-in-reset state cannot record.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_found && !reset) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state and datapath update for the IDLE/WAIT/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    id_d     = id_q;
    rsp_z_d  = rsp_z_q;
`ifdef MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          mul_a_d  = sel_a;
          mul_b_d  = sel_b;
          id_d     = grant_idx;
          rr_ptr_d = grant_idx;
          cnt_d    = '0;
          state_d  = ST_WAIT;
`ifdef MULT_SIGNED_EN
          // Feed magnitudes to the unsigned multiplier and remember the
          // result sign; 0x80000000 negates to itself, which is the
          // correct unsigned magnitude.
          neg_d = 1'b0;
          if (sel_signed) begin
            mul_a_d = sel_a[31] ? (~sel_a + 32'd1) : sel_a;
            mul_b_d = sel_b[31] ? (~sel_b + 32'd1) : sel_b;
            neg_d   = sel_a[31] ^ sel_b[31];
          end
`endif
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(MUL_LAT)) begin
`ifdef MULT_SIGNED_EN
          rsp_z_d = neg_q ? (~mul_z_i + 64'd1) : mul_z_i;
`else
          rsp_z_d = mul_z_i;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; an asserted reset discards any op in flight.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every register here is a handful of flops, so all of them are
      // reset; there is no storage array that would be left unreset.
      state_q  <= ST_IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      id_q     <= '0;
      rsp_z_q  <= '0;
`ifdef MULT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      id_q     <= id_d;
      rsp_z_q  <= rsp_z_d;
`ifdef MULT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

`ifndef MULT_SIGNED_EN
  // Sign flag and its mux output have no consumer in the unsigned build.
  logic unused_signed;
  assign unused_signed = sel_signed;
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_z     = rsp_z_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;

endmodule
